// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
// Defining FETCH_MISALIGN_TRAP_EN adds the HALT state used by the misaligned-target trap.
package fetch_pkg;

    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [31:0] PC_STEP           = 32'd4;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        HALT  = 2'd2
`endif
    } fetch_state_t;

    function automatic logic [31:0] align_target(input logic [31:0] target);
        return target & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and imem (slave).
interface fetch_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/if_id_buffer.sv
// One-entry IF/ID register: load, drain, flush-to-NOP and synchronous reset-to-NOP.
module if_id_buffer
    import fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        drain,
    input  logic        flush,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    logic        valid_q,    valid_d;
    logic [31:0] instr_q,    instr_d;
    logic [31:0] pc_q,       pc_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;

    // Flush beats a same-cycle load; a load beats a same-cycle drain so the new entry survives.
    always_comb begin
        // NOTE: every variable gets its hold value first, so no path through this block infers a latch.
        valid_d    = valid_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        if (flush) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end else if (load) begin
            valid_d    = 1'b1;
            instr_d    = load_instr;
            pc_d       = load_pc;
            pc_plus4_d = load_pc + PC_STEP;
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
        if (reset) begin
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
            pc_q       <= 32'h0000_0000;
            pc_plus4_q <= PC_STEP;
        end else begin
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
        end
    end

    assign valid    = valid_q;
    assign instr    = instr_q;
    assign pc       = pc_q;
    assign pc_plus4 = pc_plus4_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, issues one imem request at a time, feeds the IF/ID buffer.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect targets raise fetch_misaligned and halt fetch.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        b_sel,
    input  logic [31:0] sum,
    fetch_if.master     imem,
    output logic        if_valid,
    input  logic        id_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        fetch_misaligned
`endif
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         discard_q, discard_d;

    logic [31:0]  target;
    logic         space;
    logic         req_valid;
    logic         req_hs;
    logic         rsp_in_wait;
    logic         buf_load;
    logic         buf_drain;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic         misaligned_q, misaligned_d;
    logic         misaligned_redirect;

    assign target              = sum;
    assign misaligned_redirect = b_sel && (sum[1:0] != 2'b00);
    assign misaligned_d        = misaligned_q || misaligned_redirect;
    assign fetch_misaligned    = misaligned_q;
`else
    assign target = align_target(sum);
`endif

    assign space       = !if_valid || id_ready;
    assign req_valid   = !reset && (state_q == ISSUE) && space;
    assign req_hs      = req_valid && imem.imem_req_ready;
    assign rsp_in_wait = (state_q == WAIT) && imem.imem_rsp_valid;
    assign buf_load    = rsp_in_wait && !discard_q && !b_sel;
    assign buf_drain   = if_valid && id_ready;

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_addr      = pc_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        discard_d = discard_q;

        case (state_q)
            ISSUE: begin
                if (req_hs) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem.imem_rsp_valid) begin
                    state_d = ISSUE;
                    if (discard_q) begin
                        discard_d = 1'b0;
                    end else begin
                        pc_d = pc_q + PC_STEP;
                    end
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            HALT: begin
                if (imem.imem_rsp_valid) begin
                    discard_d = 1'b0;
                end
            end
`endif
            default: state_d = ISSUE;
        endcase

        // Redirect overrides the normal flow; discard marks a response that is still in flight.
        if (b_sel) begin
            pc_d = target;
            if (state_q == ISSUE) begin
                discard_d = req_hs;
            end else if (state_q == WAIT) begin
                discard_d = !imem.imem_rsp_valid;
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            if (misaligned_redirect) begin
                state_d = HALT;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ISSUE;
            pc_q      <= RESET_PC;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
        end
    end
`endif

    if_id_buffer #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_buffer (
        .clk        (clk),
        .reset      (reset),
        .load       (buf_load),
        .drain      (buf_drain),
        .flush      (b_sel),
        .load_instr (imem.imem_rsp_data),
        .load_pc    (pc_q),
        .valid      (if_valid),
        .instr      (if_instr),
        .pc         (if_pc),
        .pc_plus4   (if_pc_plus4)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a latency-programmable imem responder returns addr ^ 32'h0050_0093.
// A second instance with RESET_PC=32'hFFFF_FFFC covers PC wrap-around.
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam logic [31:0] K = 32'h0050_0093;

    logic        clk = 1'b0;
    logic        reset;
    logic        b_sel;
    logic [31:0] sum;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_instr, if_pc, if_pc_plus4;

    logic        b_sel2;
    logic [31:0] sum2;
    logic        id_ready2;
    logic        if_valid2;
    logic [31:0] if_instr2, if_pc2, if_pc_plus4_2;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misaligned;
    logic        misaligned2;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;

    int          rsp_lat;
    bit          pend;
    int          pend_cnt;
    logic [31:0] pend_addr;

    fetch_if bus ();
    fetch_if bus2 ();

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .b_sel            (b_sel),
        .sum              (sum),
        .imem             (bus.master),
        .if_valid         (if_valid),
        .id_ready         (id_ready),
        .if_instr         (if_instr),
        .if_pc            (if_pc),
        .if_pc_plus4      (if_pc_plus4)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_misaligned (misaligned)
`endif
    );

    fetch_stage #(
        .RESET_PC  (32'hFFFF_FFFC),
        .NOP_INSTR (32'h0000_0013)
    ) dut_wrap (
        .clk              (clk),
        .reset            (reset),
        .b_sel            (b_sel2),
        .sum              (sum2),
        .imem             (bus2.master),
        .if_valid         (if_valid2),
        .id_ready         (id_ready2),
        .if_instr         (if_instr2),
        .if_pc            (if_pc2),
        .if_pc_plus4      (if_pc_plus4_2)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_misaligned (misaligned2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: sample handshakes at the falling edge, then update the responders just after the rising edge.
    task automatic tick();
        logic        hs, hs2;
        logic [31:0] a, a2;
        @(negedge clk);
        hs  = bus.imem_req_valid & bus.imem_req_ready;
        a   = bus.imem_addr;
        hs2 = bus2.imem_req_valid & bus2.imem_req_ready;
        a2  = bus2.imem_addr;
        @(posedge clk);
        #1;
        bus.imem_rsp_valid = 1'b0;
        if (hs) begin
            pend      = 1'b1;
            pend_cnt  = rsp_lat;
            pend_addr = a;
        end
        if (pend) begin
            pend_cnt = pend_cnt - 1;
            if (pend_cnt == 0) begin
                pend               = 1'b0;
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = pend_addr ^ K;
            end
        end
        bus2.imem_rsp_valid = hs2;
        bus2.imem_rsp_data  = a2 ^ K;
    endtask

    initial begin
        reset     = 1'b1;
        b_sel     = 1'b0;
        sum       = 32'h0;
        id_ready  = 1'b1;
        b_sel2    = 1'b0;
        sum2      = 32'h0;
        id_ready2 = 1'b1;
        rsp_lat   = 1;
        pend      = 1'b0;
        pend_cnt  = 0;
        pend_addr = 32'h0;
        bus.imem_req_ready  = 1'b1;
        bus.imem_rsp_valid  = 1'b0;
        bus.imem_rsp_data   = 32'h0;
        bus2.imem_req_ready = 1'b1;
        bus2.imem_rsp_valid = 1'b0;
        bus2.imem_rsp_data  = 32'h0;

        tick(); tick(); #1;
        check("rst_req_valid",   32'(bus.imem_req_valid), 32'd0);
        check("rst_if_valid",    32'(if_valid), 32'd0);
        check("rst_if_instr",    if_instr, 32'h0000_0013);
        check("rst_if_pc",       if_pc, 32'h0);
        check("rst_if_pc_plus4", if_pc_plus4, 32'h4);
        check("rst_addr",        bus.imem_addr, 32'h0);
        check("rst_wrap_addr",   bus2.imem_addr, 32'hFFFF_FFFC);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("rst_misaligned",  32'(misaligned), 32'd0);
`endif

        // First fetch out of reset.
        reset = 1'b0; #1;
        check("c0_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("c0_addr",      bus.imem_addr, 32'h0);
        tick(); #1;
        check("c1_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("c1_if_valid",  32'(if_valid), 32'd0);

        // Buffer full and decode stalled for five cycles.
        tick(); id_ready = 1'b0; #1;
        check("c2_if_valid",    32'(if_valid), 32'd1);
        check("c2_if_instr",    if_instr, 32'h0050_0093);
        check("c2_if_pc",       if_pc, 32'h0);
        check("c2_if_pc_plus4", if_pc_plus4, 32'h4);
        check("c2_addr",        bus.imem_addr, 32'h4);
        check("c2_req_valid",   32'(bus.imem_req_valid), 32'd0);
        check("wrap_if_pc",       if_pc2, 32'hFFFF_FFFC);
        check("wrap_if_pc_plus4", if_pc_plus4_2, 32'h0);
        check("wrap_if_instr",    if_instr2, 32'hFFAF_FF6F);
        check("wrap_second_addr", bus2.imem_addr, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            check("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
            check("stall_if_pc",     if_pc, 32'h0);
        end
        tick(); id_ready = 1'b1; #1;
        check("resume_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("resume_addr",      bus.imem_addr, 32'h4);
        tick(); #1;
        check("drain_if_valid", 32'(if_valid), 32'd0);

        // Redirect to 0x100 in the same cycle the request for 8 is accepted.
        tick(); b_sel = 1'b1; sum = 32'h100; #1;
        check("c9_if_pc",     if_pc, 32'h4);
        check("c9_if_instr",  if_instr, 32'h0050_0097);
        check("c9_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("c9_addr",      bus.imem_addr, 32'h8);
        tick(); b_sel = 1'b0; #1;
        check("flush_if_valid",  32'(if_valid), 32'd0);
        check("flush_if_instr",  if_instr, 32'h0000_0013);
        check("flush_req_valid", 32'(bus.imem_req_valid), 32'd0);
        tick(); #1;
        check("drop_if_valid",   32'(if_valid), 32'd0);
        check("redir_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("redir_addr",      bus.imem_addr, 32'h100);
        tick(); #1;
        tick(); #1;
        check("tgt_if_valid",    32'(if_valid), 32'd1);
        check("tgt_if_pc",       if_pc, 32'h100);
        check("tgt_if_instr",    if_instr, 32'h0050_0193);
        check("tgt_if_pc_plus4", if_pc_plus4, 32'h104);
        check("tgt_next_addr",   bus.imem_addr, 32'h104);

        // Redirect coinciding with the response.
        tick(); b_sel = 1'b1; sum = 32'h200; #1;
        check("c14_if_valid", 32'(if_valid), 32'd0);
        tick(); b_sel = 1'b0; #1;
        check("rsp_redir_if_valid",  32'(if_valid), 32'd0);
        check("rsp_redir_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("rsp_redir_addr",      bus.imem_addr, 32'h200);
        tick(); #1;
        tick(); #1;
        check("post_discard_if_valid", 32'(if_valid), 32'd1);
        check("post_discard_if_pc",    if_pc, 32'h200);
        check("post_discard_if_instr", if_instr, 32'h0050_0293);
        check("post_discard_addr",     bus.imem_addr, 32'h204);

        // Back-to-back redirects while a slow response is outstanding.
        rsp_lat = 3;
        tick(); b_sel = 1'b1; sum = 32'h300; #1;
        check("b2b_c18_if_valid",  32'(if_valid), 32'd0);
        check("b2b_c18_req_valid", 32'(bus.imem_req_valid), 32'd0);
        tick(); sum = 32'h400; #1;
        check("b2b_c19_req_valid", 32'(bus.imem_req_valid), 32'd0);
        tick(); b_sel = 1'b0; #1;
        check("b2b_c20_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("b2b_c20_if_valid",  32'(if_valid), 32'd0);
        tick(); rsp_lat = 1; #1;
        check("b2b_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("b2b_addr",      bus.imem_addr, 32'h400);
        check("b2b_if_valid",  32'(if_valid), 32'd0);
        tick(); #1;
        tick(); #1;
        check("b2b_buf_if_pc",    if_pc, 32'h400);
        check("b2b_buf_if_instr", if_instr, 32'h0050_0493);
        check("b2b_buf_addr",     bus.imem_addr, 32'h404);

        // Misaligned target while the request is not accepted.
        bus.imem_req_ready = 1'b0; b_sel = 1'b1; sum = 32'h102; #1;
        check("noack_req_valid", 32'(bus.imem_req_valid), 32'd1);
        tick(); b_sel = 1'b0; bus.imem_req_ready = 1'b1; #1;
`ifdef FETCH_MISALIGN_TRAP_EN
        check("trap_flag",      32'(misaligned), 32'd1);
        check("trap_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("trap_addr",      bus.imem_addr, 32'h102);
        check("trap_if_valid",  32'(if_valid), 32'd0);
        tick(); #1;
        tick(); #1;
        check("halt_flag",      32'(misaligned), 32'd1);
        check("halt_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("halt_if_valid",  32'(if_valid), 32'd0);
`else
        check("align_if_valid",  32'(if_valid), 32'd0);
        check("align_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("align_addr",      bus.imem_addr, 32'h100);
        tick(); #1;
        tick(); #1;
        check("align_buf_if_valid", 32'(if_valid), 32'd1);
        check("align_buf_if_pc",    if_pc, 32'h100);
        check("align_buf_pc_plus4", if_pc_plus4, 32'h104);
`endif

        // Reset from mid-stream.
        reset = 1'b1;
        tick(); #1;
        check("rerst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("rerst_if_valid",  32'(if_valid), 32'd0);
        check("rerst_if_instr",  if_instr, 32'h0000_0013);
        check("rerst_addr",      bus.imem_addr, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("rerst_misaligned", 32'(misaligned), 32'd0);
`endif
        reset = 1'b0; #1;
        check("rerst_issue", 32'(bus.imem_req_valid), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
